// File: rtl/program_loader.sv
// Frames a host byte stream into 28-bit MiniAlu instructions and writes them
// into instruction RAM, holding the CPU in reset until the load completes.
module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [27:0]           oInstruction,
    output logic                  oCpuHold,
    output logic                  oDone,
    output logic                  oError,
    output logic [15:0]           oWordCount
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LEN_HI  = 3'd1;
    localparam logic [2:0] LEN_LO  = 3'd2;
    localparam logic [2:0] COLLECT = 3'd3;
    localparam logic [2:0] WRITE   = 3'd4;
    localparam logic [2:0] CHECK   = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]            state;
    logic [7:0]            lenHi;
    logic [15:0]           frameLen;
    logic [1:0]            byteIdx;
    logic [15:0]           wordIdx;
    logic [7:0]            xorAcc;
    logic                  errFlag;
    logic [19:0]           asmReg;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [27:0]           instr;

    logic        accept;
    logic [15:0] lenNext;
    logic [15:0] wordNext;
    logic        tooLong;

    assign accept   = iByteValid && oByteReady;
    assign lenNext  = {lenHi, iByte};
    assign wordNext = wordIdx + 16'd1;
    assign tooLong  = {1'b0, lenNext} > 17'(DEPTH);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state     <= IDLE;
            lenHi     <= 8'h00;
            frameLen  <= 16'h0000;
            byteIdx   <= 2'd0;
            wordIdx   <= 16'h0000;
            xorAcc    <= 8'h00;
            errFlag   <= 1'b0;
            asmReg    <= 20'h00000;
            writeAddr <= '0;
            instr     <= 28'h0000000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (iStart) begin
                        state   <= LEN_HI;
                        wordIdx <= 16'h0000;
                        errFlag <= 1'b0;
                        xorAcc  <= 8'h00;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        lenHi  <= iByte;
                        xorAcc <= xorAcc ^ iByte;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        frameLen <= lenNext;
                        xorAcc   <= xorAcc ^ iByte;
                        byteIdx  <= 2'd0;
                        if (lenNext == 16'h0000) begin
                            state <= CHECK;
                        end else if (tooLong) begin
                            errFlag <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        xorAcc  <= xorAcc ^ iByte;
                        byteIdx <= byteIdx + 2'd1;
                        case (byteIdx)
                            2'd0: begin
                                asmReg <= {16'h0000, iByte[3:0]};
                                if (iByte[7:4] != 4'h0) begin
                                    errFlag <= 1'b1;
                                end
                            end
                            2'd1, 2'd2: begin
                                asmReg <= {asmReg[11:0], iByte};
                            end
                            default: begin
                                // Latch the word here so it is stable for all of WRITE.
                                instr     <= {asmReg, iByte};
                                writeAddr <= ADDR_WIDTH'(wordIdx);
                                state     <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    wordIdx <= wordNext;
                    byteIdx <= 2'd0;
                    if (wordNext == frameLen) begin
                        state <= CHECK;
                    end else begin
                        state <= COLLECT;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if (iByte != xorAcc) begin
                            errFlag <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        oByteReady = 1'b0;
        oCpuHold   = 1'b0;
        case (state)
            LEN_HI, LEN_LO, COLLECT, CHECK: begin
                oByteReady = 1'b1;
                oCpuHold   = 1'b1;
            end
            WRITE: begin
                oCpuHold = 1'b1;
            end
            default: begin
                oByteReady = 1'b0;
                oCpuHold   = 1'b0;
            end
        endcase
    end

    assign oWriteEnable  = (state == WRITE);
    assign oDone         = (state == DONE);
    assign oError        = oDone && errFlag;
    assign oWordCount    = wordIdx;
    assign oWriteAddress = writeAddr;
    assign oInstruction  = instr;

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream writer for the MiniAlu instruction memory. It receives a framed program over a valid/ready byte interface, assembles big-endian 4-byte groups into 28-bit instructions, and writes them into the program RAM that the CPU fetch stage reads. It holds the CPU in reset while loading and reports completion and checksum status. It sits between the host link (UART/debug receiver) and the write port of the instruction RAM.

## Interface
- ADDR_WIDTH, 16, instruction RAM address width; matches the CPU instruction pointer width.
- DEPTH, 256, number of writable instruction words; valid addresses are 0..DEPTH-1.
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the rising edge of Clock).
- iStart  input  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE.
- iByte  input  8  incoming stream byte.
- iByteValid  input  1  iByte is valid this cycle.
- oByteReady  output  1  loader accepts iByte this cycle; a transfer occurs when iByteValid && oByteReady at the edge.
- oWriteEnable  output  1  one-cycle write strobe to the instruction RAM.
- oWriteAddress  output  ADDR_WIDTH  instruction RAM write address.
- oInstruction  output  28  instruction word to write.
- oCpuHold  output  1  high from the accepted iStart until DONE; ORed into the CPU reset.
- oDone  output  1  high in DONE and held until the next iStart or reset.
- oError  output  1  valid while oDone is high: checksum mismatch, nonzero top nibble, or length > DEPTH.
- oWordCount  output  16  number of instructions written in the current or last load.

## Operation
- Frame format: LEN_HI, LEN_LO (N = {LEN_HI, LEN_LO}), then N instructions of 4 bytes each, most significant byte first, then one checksum byte.
- Instruction assembly: byte0[3:0] → instr[27:24], byte1 → [23:16], byte2 → [15:8], byte3 → [7:0]. A nonzero byte0[7:4] sets a sticky error flag; the word is still written.
- Checksum: XOR of every frame byte before it, including both length bytes. A mismatch sets the sticky error flag.
- States and transitions:
  - IDLE: entered on reset. iStart → LEN_HI.
  - LEN_HI → LEN_LO on accepted byte.
  - LEN_LO, on accepted byte:
    - N == 0 → CHECK.
    - N > DEPTH → DONE with oError=1; no further bytes are accepted.
    - Otherwise → COLLECT.
  - COLLECT: a 2-bit byte index counts 0..3. After byte 3 is accepted → WRITE.
  - WRITE: lasts exactly one cycle. oWriteEnable=1, oWriteAddress=word index, oInstruction holds the assembled word. The word index increments. If index+1 == N → CHECK, else → COLLECT with byte index 0.
  - CHECK: one accepted byte → DONE.
  - DONE: iStart → LEN_HI. The word count, error flag and XOR accumulator all clear on that start.
- oByteReady=1 only in LEN_HI, LEN_LO, COLLECT and CHECK. It is 0 in IDLE, WRITE and DONE, so no byte is lost during WRITE.
- iStart in any other state is ignored. iByteValid in a not-ready state is ignored; the sender must hold the byte.
- Reset (Reset=0) mid-load: the loader returns to IDLE immediately and all outputs take their reset values. Already-written RAM words are not undone.

## Timing
- Reset values: oByteReady=0, oWriteEnable=0, oWriteAddress=0, oInstruction=0, oCpuHold=0, oDone=0, oError=0, oWordCount=0.
- All outputs are registered, or decoded from registered state only. There are no combinational paths from iByte or iByteValid to any output.
- oCpuHold rises the cycle after iStart is sampled. It falls in the same cycle oDone rises.
- Write latency: oWriteEnable is high in the cycle immediately after the edge that accepted byte 3.
- oWriteAddress and oInstruction are stable for the whole WRITE cycle. They keep their values afterwards until the next WRITE.
- oWordCount updates on the edge ending WRITE.
- Throughput with iByteValid held high: 5 cycles per instruction (4 accept cycles + 1 WRITE). Full frame = 2 + 5N + 1 cycles from LEN_HI to DONE.
- Simultaneous iStart and Reset=0: reset wins.

## Test plan
- Reset: hold Reset=0 for 3 cycles → every output at its reset value, state IDLE, oByteReady=0.
- Single word: iStart, then bytes 00 01 03 05 04 0C 05 (checksum 01^03^05^04^0C=0F; send 0F instead of 05 for the pass case) → one write to addr 0 of 28'h3050_40C; oDone=1, oError=0, oWordCount=1.
- Three words, iByteValid toggled 50%:
  - Words written to addresses 0, 1, 2 in order with no duplicated or dropped byte.
  - oByteReady=0 during each WRITE cycle.
  - Correct checksum → oError=0.
- Bad checksum: same frame with the checksum byte flipped → all words still written; oDone=1, oError=1.
- Boundaries:
  - N=0 with checksum 00 → no write; oDone=1, oError=0.
  - N=DEPTH+1 → DONE right after LEN_LO, oError=1, zero writes.
  - byte0=0x15 → word written as 28'h5xx_xxxx with oError=1.
- Reset mid-frame: drive Reset=0 after 2 words of a 4-word load → IDLE next cycle, oCpuHold=0. A subsequent full load completes normally.
